gerenciador_jogadas: RTL and testbench

- Owns the 3-slot table of target moves (squares) the player must hit.
- Sequences the shared move generator to fill the table on game start and to replace a slot after a hit.
- Checks each player move against the table through one shared comparator, one slot per cycle.
- Sits between the game control unit (iniciar/verificar pulses; pronto/acertou back) and the pseudo-random move generator.

---
 rtl/gerenciador_jogadas.sv | 146 ++++++++++++++
 tb/tb_gerenciador_jogadas.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gerenciador_jogadas.sv
// Keeps the table of target squares: fills it from the shared move generator,
// checks player moves one slot per cycle and refreshes a slot after a hit.
module gerenciador_jogadas #(
    parameter int N_SLOTS  = 3,
    parameter int W_JOG    = 6,
    parameter int MAX_TENT = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       iniciar,
    input  logic                       verificar,
    input  logic [W_JOG-1:0]           jogada,
    output logic                       gen_req,
    input  logic                       gen_ack,
    input  logic [W_JOG-1:0]           gen_dado,
    output logic                       ocupado,
    output logic                       pronto,
    output logic                       acertou,
    output logic [1:0]                 indice_acerto,
    output logic [N_SLOTS-1:0]         validos,
    output logic [N_SLOTS*W_JOG-1:0]   alvos,
    output logic [3:0]                 db_estado
);

    localparam int            TW       = $clog2(MAX_TENT + 1);
    localparam logic [1:0]    IDX_LAST = 2'(N_SLOTS - 1);
    localparam logic [TW-1:0] TENT_LIM = TW'(MAX_TENT - 1);

    typedef enum logic [2:0] {
        OCIOSO    = 3'd0,
        COMPARA   = 3'd1,
        PEDE      = 3'd2,
        DUPLICADO = 3'd3,
        GRAVA     = 3'd4,
        FIM       = 3'd5
    } estado_t;

    estado_t                     estado;
    logic [N_SLOTS-1:0][W_JOG-1:0] slots;
    logic [1:0]                  idx;
    logic [TW-1:0]               tentativas;
    logic [W_JOG-1:0]            cand;
    logic [W_JOG-1:0]            jog_lat;
    logic                        enchendo;
    logic                        duplicado;

    // The slot being rewritten never counts as a duplicate of itself.
    always_comb begin
        duplicado = 1'b0;
        for (int j = 0; j < N_SLOTS; j++) begin
            if (validos[j] && (slots[j] == cand) && (2'(j) != idx))
                duplicado = 1'b1;
        end
    end

    assign gen_req = (estado == PEDE);
    assign ocupado = (estado != OCIOSO);
    assign pronto  = (estado == FIM);
    assign alvos   = slots;

    always_comb begin
        case (estado)
            OCIOSO:    db_estado = 4'h0;
            COMPARA:   db_estado = 4'h1;
            PEDE:      db_estado = 4'h2;
            DUPLICADO: db_estado = 4'h3;
            GRAVA:     db_estado = 4'h4;
            FIM:       db_estado = 4'hF;
            default:   db_estado = 4'hD;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado        <= OCIOSO;
            slots         <= '0;
            validos       <= '0;
            acertou       <= 1'b0;
            indice_acerto <= 2'd0;
            idx           <= 2'd0;
            tentativas    <= '0;
            cand          <= '0;
            jog_lat       <= '0;
            enchendo      <= 1'b0;
        end else begin
            case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        validos    <= '0;
                        idx        <= 2'd0;
                        tentativas <= '0;
                        enchendo   <= 1'b1;
                        estado     <= PEDE;
                    end else if (verificar) begin
                        jog_lat  <= jogada;
                        acertou  <= 1'b0;
                        idx      <= 2'd0;
                        enchendo <= 1'b0;
                        estado   <= COMPARA;
                    end
                end
                COMPARA: begin
                    if (validos[idx] && (slots[idx] == jog_lat)) begin
                        acertou       <= 1'b1;
                        indice_acerto <= idx;
                        tentativas    <= '0;
                        estado        <= PEDE;
                    end else if (idx == IDX_LAST) begin
                        acertou <= 1'b0;
                        estado  <= FIM;
                    end else begin
                        idx <= idx + 2'd1;
                    end
                end
                PEDE: begin
                    if (gen_ack) begin
                        cand   <= gen_dado;
                        estado <= DUPLICADO;
                    end
                end
                DUPLICADO: begin
                    if (duplicado && (tentativas < TENT_LIM)) begin
                        tentativas <= tentativas + 1'b1;
                        estado     <= PEDE;
                    end else begin
                        estado <= GRAVA;
                    end
                end
                GRAVA: begin
                    slots[idx]   <= cand;
                    validos[idx] <= 1'b1;
                    if (enchendo && (idx < IDX_LAST)) begin
                        idx        <= idx + 2'd1;
                        tentativas <= '0;
                        estado     <= PEDE;
                    end else begin
                        estado <= FIM;
                    end
                end
                FIM:     estado <= OCIOSO;
                default: estado <= OCIOSO;
            endcase
        end
    end

endmodule

// File: tb/tb_gerenciador_jogadas.sv
// Bench for gerenciador_jogadas: vector table applied through a scoreboard,
// a scripted move generator, plus slow-generator and abort-by-reset sequences.
module tb_gerenciador_jogadas;

    logic        clock = 1'b0;
    logic        reset;
    logic        iniciar;
    logic        verificar;
    logic [5:0]  jogada;
    logic        gen_req;
    logic        gen_ack;
    logic [5:0]  gen_dado;
    logic        ocupado;
    logic        pronto;
    logic        acertou;
    logic [1:0]  indice_acerto;
    logic [2:0]  validos;
    logic [17:0] alvos;
    logic [3:0]  db_estado;

    gerenciador_jogadas #(.N_SLOTS(3), .W_JOG(6), .MAX_TENT(4)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .verificar(verificar),
        .jogada(jogada), .gen_req(gen_req), .gen_ack(gen_ack), .gen_dado(gen_dado),
        .ocupado(ocupado), .pronto(pronto), .acertou(acertou),
        .indice_acerto(indice_acerto), .validos(validos), .alvos(alvos),
        .db_estado(db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit             ini;
        logic [5:0]     jog;
        int             ng;
        logic [4:0][5:0] g;
        bit             hit;
        logic [1:0]     idx;
        logic [17:0]    alv;
        logic [2:0]     val;
        int             lat;
        int             reqs;
    } vec_t;

    typedef struct {
        vec_t v;
        int   start;
    } sb_t;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         req_count = 0;
    int         req_high = 0;
    int         pronto_count = 0;
    int         gen_delay = 0;
    int         wait_cnt = 0;
    logic [5:0] gen_q[$];
    sb_t        sb[$];
    sb_t        mon_e;
    vec_t       vecs[11];

    function automatic logic [17:0] pack(input logic [5:0] a0, a1, a2);
        return {a2, a1, a0};
    endfunction

    function automatic vec_t mkv(input bit ini, input logic [5:0] jog, input int ng,
                                 input logic [5:0] g0, g1, g2, g3, g4,
                                 input bit hit, input logic [1:0] idx,
                                 input logic [17:0] alv, input logic [2:0] val,
                                 input int lat, input int reqs);
        vec_t v;
        v.ini = ini; v.jog = jog; v.ng = ng; v.g = {g4, g3, g2, g1, g0};
        v.hit = hit; v.idx = idx; v.alv = alv; v.val = val; v.lat = lat; v.reqs = reqs;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Scripted generator: answers each request after gen_delay waiting cycles.
    initial begin
        gen_ack = 1'b0;
        gen_dado = '0;
        forever begin
            @(negedge clock);
            if (gen_ack) begin
                void'(gen_q.pop_front());
                req_count++;
                wait_cnt = 0;
                gen_ack = 1'b0;
            end else if (gen_req) begin
                if (wait_cnt >= gen_delay && gen_q.size() > 0) begin
                    gen_ack = 1'b1;
                    gen_dado = gen_q[0];
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (gen_req) req_high++;
        if (reset && pronto) begin
            pronto_count++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pronto actual=1 required=0");
            end else begin
                mon_e = sb.pop_front();
                check("acertou", acertou, mon_e.v.hit);
                check("indice_acerto", indice_acerto, mon_e.v.idx);
                check("alvos", alvos, mon_e.v.alv);
                check("validos", validos, mon_e.v.val);
                check("latency", cyc - mon_e.start, mon_e.v.lat);
                check("gen_requests", req_count, mon_e.v.reqs);
            end
        end
    end

    task automatic apply(input vec_t v);
        sb_t s;
        gen_q.delete();
        for (int i = 0; i < v.ng; i++) gen_q.push_back(v.g[i]);
        req_count = 0;
        wait_cnt = 0;
        @(negedge clock);
        s.v = v;
        s.start = cyc;
        sb.push_back(s);
        if (v.ini) iniciar = 1'b1;
        else begin
            verificar = 1'b1;
            jogada = v.jog;
        end
        @(negedge clock);
        iniciar = 1'b0;
        verificar = 1'b0;
        jogada = ~v.jog;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (sb.size() > 0 && n < 300) begin
            @(negedge clock);
            n++;
        end
        total++;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL %s_timeout actual=%0d required=0 pending", name, sb.size());
            sb.delete();
        end
    endtask

    initial begin
        vecs[0]  = mkv(0,  5, 0,  0,  0,  0,  0,  0, 0, 0, pack( 0,  0,  0), 3'b000,  4, 0);
        vecs[1]  = mkv(1,  0, 3, 12, 40,  7,  0,  0, 0, 0, pack(12, 40,  7), 3'b111, 10, 3);
        vecs[2]  = mkv(0, 40, 1, 55,  0,  0,  0,  0, 1, 1, pack(12, 55,  7), 3'b111,  6, 1);
        vecs[3]  = mkv(0, 40, 0,  0,  0,  0,  0,  0, 0, 1, pack(12, 55,  7), 3'b111,  4, 0);
        vecs[4]  = mkv(0,  9, 0,  0,  0,  0,  0,  0, 0, 1, pack(12, 55,  7), 3'b111,  4, 0);
        vecs[5]  = mkv(0, 12, 1, 33,  0,  0,  0,  0, 1, 0, pack(33, 55,  7), 3'b111,  5, 1);
        vecs[6]  = mkv(1,  0, 3, 12, 40,  7,  0,  0, 1, 0, pack(12, 40,  7), 3'b111, 10, 3);
        vecs[7]  = mkv(0,  7, 4, 12, 12, 12, 12,  0, 1, 2, pack(12, 40, 12), 3'b111, 13, 4);
        vecs[8]  = mkv(1,  0, 3, 12, 40,  7,  0,  0, 1, 2, pack(12, 40,  7), 3'b111, 10, 3);
        vecs[9]  = mkv(0,  7, 2, 12, 30,  0,  0,  0, 1, 2, pack(12, 40, 30), 3'b111,  9, 2);
        vecs[10] = mkv(1,  0, 5,  5,  5,  9,  9, 20, 1, 2, pack( 5,  9, 20), 3'b111, 14, 5);

        reset = 1'b0;
        iniciar = 1'b0;
        verificar = 1'b0;
        jogada = '0;
        repeat (3) @(negedge clock);
        check("rst_gen_req", gen_req, 0);
        check("rst_pronto", pronto, 0);
        check("rst_acertou", acertou, 0);
        check("rst_indice", indice_acerto, 0);
        check("rst_validos", validos, 0);
        check("rst_alvos", alvos, 0);
        check("rst_db_estado", db_estado, 0);
        check("rst_ocupado", ocupado, 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            wait_done($sformatf("vec%0d", i));
        end

        // Slow generator with ignored verificar/iniciar pulses while busy.
        begin
            sb_t s;
            gen_q.delete();
            gen_q.push_back(6'd44);
            gen_delay = 5;
            wait_cnt = 0;
            req_count = 0;
            @(negedge clock);
            s.v = mkv(0, 9, 1, 44, 0, 0, 0, 0, 1, 1, pack(5, 44, 20), 3'b111, 11, 1);
            s.start = cyc;
            sb.push_back(s);
            verificar = 1'b1;
            jogada = 6'd9;
            @(negedge clock);
            verificar = 1'b0;
            jogada = 6'd20;
            req_high = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clock);
                verificar = (i == 1);
                iniciar = (i == 3);
            end
            verificar = 1'b0;
            iniciar = 1'b0;
            wait_done("slow");
            check("slow_req_high_cycles", req_high, 6);
            gen_delay = 0;
            repeat (5) @(negedge clock);
            check("slow_idle_estado", db_estado, 0);
            check("slow_alvos_after", alvos, pack(5, 44, 20));
            check("slow_acertou_hold", acertou, 1);
            check("slow_indice_hold", indice_acerto, 1);
        end

        // Reset in the middle of PEDE aborts the fill with no pronto.
        gen_q.delete();
        wait_cnt = 0;
        @(negedge clock);
        iniciar = 1'b1;
        @(negedge clock);
        iniciar = 1'b0;
        repeat (2) @(negedge clock);
        check("pede_estado", db_estado, 2);
        check("pede_gen_req", gen_req, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_gen_req", gen_req, 0);
        check("abort_validos", validos, 0);
        check("abort_alvos", alvos, 0);
        check("abort_db_estado", db_estado, 0);
        check("abort_acertou", acertou, 0);
        pronto_count = 0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (15) @(negedge clock);
        check("abort_no_pronto", pronto_count, 0);

        apply(mkv(0, 20, 0, 0, 0, 0, 0, 0, 0, 0, pack(0, 0, 0), 3'b000, 4, 0));
        wait_done("after_abort");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
